// File: rtl/handshake_pkg.sv
// Shared definitions for handshake units: buffer FSM states and a
// saturating-increment helper.
package handshake_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } hs_state_e;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= lim) ? lim : v + 64'd1;
  endfunction

endpackage

// File: rtl/handshake_const_compare_if.sv
// Token input channel and result output channel of handshake_const_compare.
interface handshake_const_compare_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] ins;
  logic                  ins_valid;
  logic                  ins_ready;
  logic                  result;
  logic                  result_valid;
  logic                  result_ready;

  modport master (
    output ins, ins_valid, result_ready,
    input  ins_ready, result, result_valid
  );

  modport slave (
    input  ins, ins_valid, result_ready,
    output ins_ready, result, result_valid
  );
endinterface

// File: rtl/handshake_skid_buffer.sv
// Generic 2-entry elastic buffer; ready and valid decode the state register
// only, so there is no combinational path from out_ready to in_ready.
module handshake_skid_buffer
  import handshake_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  hs_state_e        state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = TWO;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/handshake_const_compare.sv
// Compares each accepted token with CONST_VALUE, emits a 1-bit result token
// through a skid buffer and keeps saturating match/mismatch statistics.
module handshake_const_compare
  import handshake_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] CONST_VALUE = DATA_WIDTH'(32'h42C9EB56),
  parameter int unsigned           CNT_WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  handshake_const_compare_if.slave  bus,
  output logic [CNT_WIDTH-1:0]      match_count,
  output logic [CNT_WIDTH-1:0]      mismatch_count,
  output logic                      error_sticky
);

  logic                 eq, in_fire;
  logic [CNT_WIDTH-1:0] match_count_q, match_count_d;
  logic [CNT_WIDTH-1:0] mismatch_count_q, mismatch_count_d;
  logic                 error_sticky_q, error_sticky_d;

  assign eq      = (bus.ins == CONST_VALUE);
  assign in_fire = bus.ins_valid & bus.ins_ready;

  handshake_skid_buffer #(
    .WIDTH (1)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst),
    .in_data   (eq),
    .in_valid  (bus.ins_valid),
    .in_ready  (bus.ins_ready),
    .out_data  (bus.result),
    .out_valid (bus.result_valid),
    .out_ready (bus.result_ready)
  );

  // Statistics follow acceptance, not emission.
  always_comb begin
    match_count_d    = match_count_q;
    mismatch_count_d = mismatch_count_q;
    error_sticky_d   = error_sticky_q;
    if (in_fire) begin
      if (eq) begin
        match_count_d = CNT_WIDTH'(sat_inc(64'(match_count_q), CNT_WIDTH));
      end else begin
        mismatch_count_d = CNT_WIDTH'(sat_inc(64'(mismatch_count_q), CNT_WIDTH));
        error_sticky_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_count_q    <= '0;
      mismatch_count_q <= '0;
      error_sticky_q   <= 1'b0;
    end else begin
      match_count_q    <= match_count_d;
      mismatch_count_q <= mismatch_count_d;
      error_sticky_q   <= error_sticky_d;
    end
  end

  assign match_count    = match_count_q;
  assign mismatch_count = mismatch_count_q;
  assign error_sticky   = error_sticky_q;

endmodule

// File: tb/tb_handshake_const_compare.sv
// Randomized and directed bench for handshake_const_compare against a
// queue-based model of a 2-deep FIFO with saturating statistics.
module tb_handshake_const_compare;

  localparam logic [31:0] CONST = 32'h42C9EB56;

  logic        clk;
  logic        rst;
  logic [15:0] match_count, mismatch_count;
  logic        error_sticky;
  logic [1:0]  match_count2, mismatch_count2;
  logic        error_sticky2;

  int unsigned n_checks;
  int unsigned n_errors;

  bit          exp_q[$];
  int unsigned m_match, m_mismatch, m_match2, m_mismatch2;
  bit          m_sticky;

  handshake_const_compare_if #(.DATA_WIDTH(32)) u_if ();
  handshake_const_compare_if #(.DATA_WIDTH(32)) u_if2 ();

  assign u_if2.ins          = u_if.ins;
  assign u_if2.ins_valid    = u_if.ins_valid;
  assign u_if2.result_ready = u_if.result_ready;

  handshake_const_compare #(
    .DATA_WIDTH (32),
    .CONST_VALUE(CONST),
    .CNT_WIDTH  (16)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (u_if.slave),
    .match_count   (match_count),
    .mismatch_count(mismatch_count),
    .error_sticky  (error_sticky)
  );

  handshake_const_compare #(
    .DATA_WIDTH (32),
    .CONST_VALUE(CONST),
    .CNT_WIDTH  (2)
  ) u_dut2 (
    .clk           (clk),
    .rst           (rst),
    .bus           (u_if2.slave),
    .match_count   (match_count2),
    .mismatch_count(mismatch_count2),
    .error_sticky  (error_sticky2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v, input int unsigned lim);
    return (v >= lim) ? lim : v + 1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_match = 0; m_mismatch = 0; m_match2 = 0; m_mismatch2 = 0;
    m_sticky = 1'b0;
  endtask

  task automatic check_outputs();
    check_eq("ins_ready", u_if.ins_ready, exp_q.size() < 2);
    check_eq("result_valid", u_if.result_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) check_eq("result", u_if.result, exp_q[0]);
    check_eq("match_count", match_count, m_match);
    check_eq("mismatch_count", mismatch_count, m_mismatch);
    check_eq("error_sticky", error_sticky, m_sticky);
    check_eq("match_count_w2", match_count2, m_match2);
    check_eq("mismatch_count_w2", mismatch_count2, m_mismatch2);
    check_eq("result_valid_w2", u_if2.result_valid, exp_q.size() > 0);
  endtask

  // Drives one cycle, advances the model at the edge, checks at the negedge.
  task automatic cycle(input logic [31:0] d, input logic v, input logic rr, output bit acc);
    bit out_fire;
    u_if.ins          = d;
    u_if.ins_valid    = v;
    u_if.result_ready = rr;
    @(posedge clk);
    acc      = v && (exp_q.size() < 2);
    out_fire = (exp_q.size() > 0) && rr;
    if (out_fire) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(d == CONST);
      if (d == CONST) begin
        m_match  = sat(m_match, 65535);
        m_match2 = sat(m_match2, 3);
      end else begin
        m_mismatch  = sat(m_mismatch, 65535);
        m_mismatch2 = sat(m_mismatch2, 3);
        m_sticky    = 1'b1;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Presents one token until accepted, within a cycle budget.
  task automatic send(input logic [31:0] d, input logic rr);
    bit acc;
    int unsigned n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      cycle(d, 1'b1, rr, acc);
      n++;
    end
    if (!acc) check_eq("send_timeout", 0, 1);
  endtask

  task automatic idle(input int unsigned n, input logic rr);
    bit acc;
    for (int unsigned i = 0; i < n; i++) cycle(32'h0, 1'b0, rr, acc);
  endtask

  initial begin
    bit          acc;
    logic [31:0] d;
    n_checks = 0;
    n_errors = 0;
    model_reset();
    u_if.ins = '0; u_if.ins_valid = 1'b0; u_if.result_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs();
    check_eq("reset_result", u_if.result, 0);

    // Single matching token, then single mismatch followed by matches.
    send(CONST, 1'b1);
    check_eq("first_result", u_if.result, 1);
    idle(1, 1'b1);
    send(32'h0, 1'b1);
    for (int unsigned i = 0; i < 5; i++) send(CONST, 1'b1);
    idle(2, 1'b1);
    check_eq("sticky_held", error_sticky, 1);

    // Back-to-back alternating stream with downstream always ready.
    for (int unsigned i = 0; i < 8; i++) begin
      cycle((i % 2 == 0) ? CONST : (CONST ^ 32'h1), 1'b1, 1'b1, acc);
      check_eq("stream_accept", acc, 1);
    end
    idle(2, 1'b1);

    // Backpressure: third token must wait until the buffer drains.
    send(CONST, 1'b0);
    send(32'hDEAD_BEEF, 1'b0);
    for (int unsigned i = 0; i < 3; i++) begin
      cycle(CONST, 1'b1, 1'b0, acc);
      check_eq("held_third", acc, 0);
    end
    send(CONST, 1'b1);
    idle(4, 1'b1);

    // Randomized traffic.
    for (int unsigned i = 0; i < 400; i++) begin
      d = ($urandom_range(1, 0) == 1) ? CONST : $urandom;
      cycle(d, ($urandom_range(3, 0) != 0), ($urandom_range(2, 0) != 0), acc);
    end
    idle(3, 1'b1);

    // Asynchronous reset while the buffer is full.
    send(CONST, 1'b0);
    send(32'h1234_5678, 1'b0);
    check_eq("full_before_reset", u_if.ins_ready, 0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check_eq("async_result", u_if.result, 0);
    @(negedge clk);
    rst = 1'b1;
    idle(4, 1'b1);
    send(32'h0, 1'b1);
    idle(2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
